// File: rtl/cart_mem_arbiter_pkg.sv
// rtl/cart_mem_arbiter_pkg.sv - shared types and constants for the cart memory arbiter
package cart_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CPU_ACC,
    BK_ACC
  } arb_state_t;

  localparam logic [7:0] ARB_TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/cart_mem_arbiter_if.sv
// rtl/cart_mem_arbiter_if.sv - CPU, backup and memory-port signal bundle of the cart memory arbiter
interface cart_mem_arbiter_if #(
  parameter int AW = 25
);
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic          cpu_we;
  logic [7:0]    cpu_din;
  logic          cpu_sram;
  logic          cpu_cart;
  logic [7:0]    cpu_dout;
  logic          cpu_wait;

  logic          bk_req;
  logic [AW-1:0] bk_addr;
  logic          bk_we;
  logic [7:0]    bk_din;
  logic [7:0]    bk_dout;
  logic          bk_ack;

  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_rd;
  logic          mem_wr;
  logic [7:0]    mem_dout;
  logic          mem_ready;

  logic [1:0]    dirty;
  logic [1:0]    dirty_clr;
  logic          err;

  // master: CPU, backup engine and memory controller around the arbiter
  modport master (
    output cpu_req, cpu_addr, cpu_we, cpu_din, cpu_sram, cpu_cart,
    input  cpu_dout, cpu_wait,
    output bk_req, bk_addr, bk_we, bk_din,
    input  bk_dout, bk_ack,
    input  mem_addr, mem_din, mem_rd, mem_wr,
    output mem_dout, mem_ready,
    input  dirty, err,
    output dirty_clr
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_we, cpu_din, cpu_sram, cpu_cart,
    output cpu_dout, cpu_wait,
    input  bk_req, bk_addr, bk_we, bk_din,
    output bk_dout, bk_ack,
    output mem_addr, mem_din, mem_rd, mem_wr,
    input  mem_dout, mem_ready,
    output dirty, err,
    input  dirty_clr
  );

endinterface

// File: rtl/cart_mem_arbiter_timeout_ctr.sv
// rtl/cart_mem_arbiter_timeout_ctr.sv - access watchdog: cleared at grant, expires on its TIMEOUT-th cycle
module cart_mem_arbiter_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      cnt_q <= '0;
    end else if (en && !expire) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/cart_mem_arbiter.sv
// rtl/cart_mem_arbiter.sv - shares the cart memory port between CPU cart accesses and the SRAM backup engine
module cart_mem_arbiter
  import cart_mem_arbiter_pkg::*;
#(
  parameter int AW      = 25,
  parameter int TIMEOUT = 64
) (
  input logic               clk,
  input logic               reset,
  cart_mem_arbiter_if.slave bus
);

  arb_state_t    state_q, state_d;
  logic          cpu_pend_q, last_cpu_q, acc_we_q;
  logic [AW-1:0] cpu_addr_q, mem_addr_q;
  logic [7:0]    cpu_din_q, mem_din_q, cpu_dout_q, bk_dout_q;
  logic          cpu_we_q, cpu_sram_q, cpu_cart_q;
  logic          mem_rd_q, mem_wr_q, bk_ack_q, err_q;
  logic [1:0]    dirty_q, dirty_set;
  logic          cpu_accept, bk_avail, in_acc, expire, done, cpu_done, bk_done;
  logic          grant_cpu, grant_bk;
  logic [7:0]    rdata;

  assign cpu_accept = bus.cpu_req && !cpu_pend_q && (state_q != CPU_ACC);
  // bk_req is still high in the ack cycle; it must not re-grant the finished request
  assign bk_avail   = bus.bk_req && !bk_ack_q;
  assign in_acc     = (state_q != IDLE);
  assign done       = in_acc && (bus.mem_ready || expire);
  assign cpu_done   = done && (state_q == CPU_ACC);
  assign bk_done    = done && (state_q == BK_ACC);
  assign rdata      = bus.mem_ready ? bus.mem_dout : ARB_TIMEOUT_DATA;

  cart_mem_arbiter_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .load   (grant_cpu || grant_bk),
    .en     (in_acc),
    .expire (expire)
  );

  // A CPU request arriving alongside bk_req counts as pending, so a CPU turn is not lost
  // to the backup while the request is still being captured.
  always_comb begin
    state_d   = state_q;
    grant_cpu = 1'b0;
    grant_bk  = 1'b0;
    case (state_q)
      IDLE: begin
        if ((cpu_pend_q || cpu_accept) && bk_avail) begin
          if (last_cpu_q) grant_bk = 1'b1;
          else            grant_cpu = cpu_pend_q;
        end else if (cpu_pend_q) begin
          grant_cpu = 1'b1;
        end else if (bk_avail) begin
          grant_bk = 1'b1;
        end
        if (grant_cpu)     state_d = CPU_ACC;
        else if (grant_bk) state_d = BK_ACC;
      end
      CPU_ACC, BK_ACC: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dirty_set = 2'b00;
    if (cpu_done && cpu_we_q && cpu_sram_q) dirty_set[cpu_cart_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cpu_pend_q <= 1'b0;
      last_cpu_q <= 1'b0;
      acc_we_q   <= 1'b0;
      cpu_addr_q <= '0;
      cpu_din_q  <= 8'h00;
      cpu_we_q   <= 1'b0;
      cpu_sram_q <= 1'b0;
      cpu_cart_q <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= 8'h00;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      bk_ack_q   <= 1'b0;
      cpu_dout_q <= 8'hFF;
      bk_dout_q  <= 8'hFF;
      dirty_q    <= 2'b00;
      err_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      bk_ack_q <= 1'b0;
      dirty_q  <= (dirty_q & ~bus.dirty_clr) | dirty_set;
      if (cpu_accept) begin
        cpu_pend_q <= 1'b1;
        cpu_addr_q <= bus.cpu_addr;
        cpu_we_q   <= bus.cpu_we;
        cpu_din_q  <= bus.cpu_din;
        cpu_sram_q <= bus.cpu_sram;
        cpu_cart_q <= bus.cpu_cart;
      end
      if (grant_cpu) begin
        cpu_pend_q <= 1'b0;
        mem_addr_q <= cpu_addr_q;
        mem_din_q  <= cpu_din_q;
        mem_rd_q   <= !cpu_we_q;
        mem_wr_q   <= cpu_we_q;
        acc_we_q   <= cpu_we_q;
      end else if (grant_bk) begin
        mem_addr_q <= bus.bk_addr;
        mem_din_q  <= bus.bk_din;
        mem_rd_q   <= !bus.bk_we;
        mem_wr_q   <= bus.bk_we;
        acc_we_q   <= bus.bk_we;
      end
      if (done && !bus.mem_ready) err_q <= 1'b1;
      if (cpu_done) begin
        last_cpu_q <= 1'b1;
        if (!acc_we_q) cpu_dout_q <= rdata;
      end
      if (bk_done) begin
        last_cpu_q <= 1'b0;
        bk_ack_q   <= 1'b1;
        if (!acc_we_q) bk_dout_q <= rdata;
      end
    end
  end

  assign bus.cpu_wait = bus.cpu_req || cpu_pend_q || (state_q == CPU_ACC);
  assign bus.cpu_dout = cpu_dout_q;
  assign bus.bk_dout  = bk_dout_q;
  assign bus.bk_ack   = bk_ack_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_wr   = mem_wr_q;
  assign bus.dirty    = dirty_q;
  assign bus.err      = err_q;

endmodule
